// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and state encoding for the UART TX scheduler.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_LOAD_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_HOLD_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_LOAD = ST_LOAD_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_HOLD = ST_HOLD_ENC
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker; first requester after i_ptr wins.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_any,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  int w_cand;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[w_cand]) begin
        o_any   = 1'b1;
        o_grant = NUM_REQ'(1) << w_cand;
        o_idx   = IDX_W'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin sharing of one UART transmitter between NUM_REQ byte
//            requesters. Define UART_TX_SCHED_LOCK_EN to keep a message together.
// Revision : 1.0
// ============================================================================
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic                           o_tx_dv,
  output logic [UART_BYTE_W-1:0]         o_tx_byte,
  input  logic                           i_tx_active,
  input  logic                           i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
  output logic                           o_busy,
  output logic                           o_lock_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 16;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("uart_tx_scheduler: NUM_REQ must be at least 2");
  end

  sched_state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
  logic                   r_tx_dv, w_tx_dv_nxt;
  logic [UART_BYTE_W-1:0] r_tx_byte, w_tx_byte_nxt;
  logic [NUM_REQ-1:0]     r_ack, w_ack_nxt;
  logic [IDX_W-1:0]       r_grant_id, w_grant_id_nxt;

  logic                   w_capture;
  logic [IDX_W-1:0]       w_cap_idx;
  logic [NUM_REQ-1:0]     w_cap_ack;

  logic                   w_arb_any;
  logic [NUM_REQ-1:0]     w_arb_grant;
  logic [IDX_W-1:0]       w_arb_idx;

`ifdef UART_TX_SCHED_LOCK_EN
  logic                   r_last, w_last_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_lock_timeout, w_lock_timeout_nxt;
`else
  logic                   w_unused_nolock;
  assign w_unused_nolock = (^i_req_last) ^ (HOLD_TIMEOUT == 0) ^ (CNT_W == 0);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_any   (w_arb_any),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_tx_dv_nxt    = 1'b0;
    w_tx_byte_nxt  = r_tx_byte;
    w_ack_nxt      = '0;
    w_grant_id_nxt = r_grant_id;
    w_capture      = 1'b0;
    w_cap_idx      = w_arb_idx;
    w_cap_ack      = w_arb_grant;
`ifdef UART_TX_SCHED_LOCK_EN
    w_last_nxt         = r_last;
    w_cnt_nxt          = r_cnt;
    w_lock_timeout_nxt = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_arb_any && !i_tx_active) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done pulse is only meaningful once the transmitter owns our byte.
        if (i_tx_done) begin
          w_ptr_nxt   = r_grant_id;
          w_state_nxt = ST_IDLE;
`ifdef UART_TX_SCHED_LOCK_EN
          if (!r_last) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end
`endif
        end
      end
`ifdef UART_TX_SCHED_LOCK_EN
      ST_HOLD: begin
        if (i_req[r_grant_id]) begin
          w_capture   = 1'b1;
          w_cap_idx   = r_grant_id;
          w_cap_ack   = NUM_REQ'(1) << r_grant_id;
          w_state_nxt = ST_LOAD;
        end else if (r_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
          w_lock_timeout_nxt = 1'b1;
          w_state_nxt        = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_capture) begin
      w_tx_dv_nxt    = 1'b1;
      w_tx_byte_nxt  = i_req_byte[UART_BYTE_W*w_cap_idx +: UART_BYTE_W];
      w_ack_nxt      = w_cap_ack;
      w_grant_id_nxt = w_cap_idx;
`ifdef UART_TX_SCHED_LOCK_EN
      w_last_nxt     = i_req_last[w_cap_idx];
`endif
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= '0;
      r_ack      <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_tx_dv    <= w_tx_dv_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_ack      <= w_ack_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

`ifdef UART_TX_SCHED_LOCK_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last         <= 1'b0;
      r_cnt          <= '0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_last         <= w_last_nxt;
      r_cnt          <= w_cnt_nxt;
      r_lock_timeout <= w_lock_timeout_nxt;
    end
  end

  assign o_lock_timeout = r_lock_timeout;
`else
  assign o_lock_timeout = 1'b0;
`endif

  assign o_tx_dv    = r_tx_dv;
  assign o_tx_byte  = r_tx_byte;
  assign o_ack      = r_ack;
  assign o_grant_id = r_grant_id;
  assign o_busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

- Shares one UART transmitter between `NUM_REQ` byte requesters using round-robin arbitration.
- Sits between client logic and the transmitter's byte interface (`i_tx_dv`/`i_tx_byte`/`o_tx_active`/`o_tx_done` on the transmitter side).
- Hands the transmitter one byte at a time and waits for its done pulse before the next grant.
- Optionally locks the grant to one requester until that requester's message is complete.

## Interface
- `NUM_REQ`, default 4: number of requesters; minimum 2.
- `HOLD_TIMEOUT`, default 1023: maximum number of cycles spent in HOLD waiting for the locked requester's next byte; 1 to 65535.
- `i_clock`  in  1: sole clock; all logic on rising edge.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_req`  in  `NUM_REQ`: bit n high = requester n has a byte pending.
- `i_req_byte`  in  `8*NUM_REQ`: byte of requester n at bits [8n+7:8n].
- `i_req_last`  in  `NUM_REQ`: byte of requester n is the last byte of its message.
- `o_ack`  out  `NUM_REQ`: one-cycle one-hot pulse; requester's byte has been captured.
- `o_tx_dv`  out  1: one-cycle start pulse to the transmitter.
- `o_tx_byte`  out  8: byte to the transmitter; valid when `o_tx_dv`=1.
- `i_tx_active`  in  1: transmitter is busy.
- `i_tx_done`  in  1: transmitter finished a byte (one-cycle pulse).
- `o_grant_id`  out  `$clog2(NUM_REQ)`: current owner; valid while `o_busy`=1.
- `o_busy`  out  1: state is not IDLE.
- `o_lock_timeout`  out  1: one-cycle pulse when a HOLD expires.

## Operation
- States: IDLE, LOAD, WAIT, HOLD.
- **IDLE:**
  - If any `i_req` is high and `i_tx_active`=0, pick the first requesting index scanning from `ptr+1` mod `NUM_REQ` upward.
  - On the clock edge, register `o_tx_byte`←byte[g], `last_r`←`i_req_last`[g], `o_grant_id`←g, `o_ack`←onehot(g), `o_tx_dv`←1; go to LOAD.
  - If `i_tx_active`=1, stay in IDLE.
- **LOAD** (exactly one cycle): `o_tx_dv` and `o_ack` are high. Go to WAIT; both drop next cycle.
- **WAIT:**
  - `i_tx_done` is sampled only in this state; a done pulse coincident with LOAD is ignored.
  - On `i_tx_done`: `ptr`←g. Go to HOLD if locking is enabled and `last_r`=0; otherwise go to IDLE.
- **HOLD:**
  - Counter clears on entry and increments every cycle.
  - If `i_req`[g]=1, capture exactly as in IDLE (other requesters are ignored) and go to LOAD.
  - If the counter reaches `HOLD_TIMEOUT`-1 without `i_req`[g], pulse `o_lock_timeout` and go to IDLE.
  - In HOLD, `i_tx_active` is ignored.
- **Capture:** bytes are registered on grant, so a requester may change `i_req_byte` or drop `i_req` from the LOAD cycle onward. A requester dropping `i_req` before it is granted loses nothing.
- **Priority:** no requester is granted twice while another requester waits, except inside a locked message.
- **Reset** (asynchronous, any state):
  - State→IDLE, `ptr`←`NUM_REQ`-1 (requester 0 wins first), counter←0.
  - `o_tx_dv`, `o_tx_byte`, `o_ack`, `o_grant_id`, `o_busy`, `o_lock_timeout` all←0.
  - An in-flight transmitter byte completes unobserved; its done pulse arrives in IDLE and is ignored.

## Timing
- Request seen in IDLE at cycle 0 → `o_tx_dv`/`o_ack` high in cycle 1.
- Done pulse in WAIT at cycle k → IDLE or HOLD in cycle k+1 → earliest next `o_tx_dv` in cycle k+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `UART_TX_SCHED_LOCK_EN` defined:
  - HOLD state, timeout counter, `last_r` and `o_lock_timeout` logic are present.
  - A message is sent contiguously.
- Not defined:
  - `i_req_last` is ignored and `o_lock_timeout` is tied 0.
  - WAIT always returns to IDLE, so arbitration happens per byte.

## Structure
- Package `uart_pkg`: state encoding constants (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2, HOLD=2'd3) and `UART_BYTE_W`=8.
- Sub-module `rr_arbiter`: combinational block; inputs `req`[`NUM_REQ`] and `ptr`; outputs `any`, onehot grant and index. Reused by future shared-resource controllers.

## Test plan
1. Reset, then `i_req`=4'b0100, byte2=0xA5 → cycle 1: `o_tx_dv`=1, `o_tx_byte`=0xA5, `o_ack`=4'b0100, `o_grant_id`=2. After `i_tx_done`, `o_busy`=0.
2. Reset, then `i_req`=4'b1111 held, transmitter model with done 10 cycles after dv → grant order 0,1,2,3,0.
3. `i_req`=4'b0001 while `i_tx_active`=1 for 20 cycles → no `o_tx_dv` until the cycle after `i_tx_active` falls.
4. LOCK_EN: requester 1 sends 0x11, 0x22, 0x33 (last on 0x33) while requester 0 requests continuously → transmitter sees 0x11, 0x22, 0x33, then requester 0's byte.
5. LOCK_EN, `HOLD_TIMEOUT`=16: requester 1 sends non-last 0x44 then drops `i_req` → `o_lock_timeout` pulses 16 cycles after HOLD entry; requester 0 is then granted.
6. `i_reset` pulsed during WAIT with grant 3 → all outputs 0 immediately; with all requesting, the next grant is 0; the stale `i_tx_done` causes no action.
